// File: rtl/neopixel_frame_sequencer.sv
// Fetches num_pixels GRB words from pixel RAM, hands each to the serializer, then enforces the strip latch gap.
// 3 cycles per pixel when unstalled; pix_valid holds until pix_ready, and the gap counts only ser_idle cycles.
module neopixel_frame_sequencer #(
    parameter int ADDR_W       = 8,
    parameter int RESET_CYCLES = 2500
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              start,
    input  logic              abort,
    input  logic              continuous,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_pixels,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [23:0]       mem_rd_data,
    output logic              pix_valid,
    output logic [23:0]       pix_data,
    input  logic              pix_ready,
    input  logic              ser_idle,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frame_count
);

    localparam int GAP_W = $clog2(RESET_CYCLES);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(RESET_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   NUM_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   NUM_ZERO = '0;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_LATCH = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   num_q, num_d;
    logic              cont_q, cont_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [23:0]       pix_q, pix_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              last_pix;

    assign last_pix = ({1'b0, idx_q} == (num_q - NUM_ONE));

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        num_d       = num_q;
        cont_d      = cont_q;
        idx_d       = idx_q;
        gap_d       = '0;
        pix_d       = pix_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    num_d   = num_pixels;
                    cont_d  = continuous;
                    idx_d   = '0;
                    state_d = (num_pixels == NUM_ZERO) ? S_LATCH : S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = abort ? S_LATCH : S_LOAD;
            end
            S_LOAD: begin
                // An aborted fetch never reaches pix_data.
                if (abort) begin
                    state_d = S_LATCH;
                end else begin
                    pix_d   = mem_rd_data;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (pix_ready) begin
                    if (last_pix || abort) begin
                        state_d = S_LATCH;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = S_FETCH;
                    end
                end
            end
            S_LATCH: begin
                // Any activity on the line restarts the gap from zero.
                if (ser_idle) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        gap_d = gap_q + GAP_ONE;
                    end
                end
            end
            S_DONE: begin
                frame_cnt_d = frame_cnt_q + 16'd1;
                if (!cont_q || abort) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = '0;
                    state_d = (num_q == NUM_ZERO) ? S_LATCH : S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            num_q       <= '0;
            cont_q      <= 1'b0;
            idx_q       <= '0;
            gap_q       <= '0;
            pix_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            num_q       <= num_d;
            cont_q      <= cont_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            pix_q       <= pix_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign mem_rd_en   = (state_q == S_FETCH);
    assign mem_addr    = base_q + idx_q;
    assign pix_valid   = (state_q == S_SEND);
    assign pix_data    = pix_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_neopixel_frame_sequencer.sv
// Directed bench for neopixel_frame_sequencer with a registered-read RAM model.
module tb_neopixel_frame_sequencer;

    localparam int R = 20;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        continuous = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [8:0]  num_pixels = '0;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [23:0] mem_rd_data = '0;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_ready = 1'b1;
    logic        ser_idle = 1'b1;
    logic        busy;
    logic        done;
    logic [15:0] frame_count;

    neopixel_frame_sequencer #(.ADDR_W(8), .RESET_CYCLES(R)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .abort(abort),
        .continuous(continuous), .base_addr(base_addr), .num_pixels(num_pixels),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .ser_idle(ser_idle), .busy(busy), .done(done), .frame_count(frame_count)
    );

    always #5 ACLK = ~ACLK;

    logic [23:0] ram [0:255];
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = {i[7:0], i[7:0], i[7:0]};
    end
    always @(posedge ACLK) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

    int cyc = 0, rd_cnt = 0, hs_cnt = 0, done_cnt = 0;
    int done_cyc = 0, last_hs_cyc = 0, stall_err = 0;
    logic [7:0]  rd_log [$];
    logic [23:0] hs_log [$];
    logic        prev_valid = 1'b0, prev_hs = 1'b0;
    logic [23:0] prev_data = '0;

    always @(negedge ACLK) begin
        cyc <= cyc + 1;
        if (mem_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            rd_log.push_back(mem_addr);
        end
        if (pix_valid && pix_ready) begin
            hs_cnt      <= hs_cnt + 1;
            last_hs_cyc <= cyc;
            hs_log.push_back(pix_data);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (pix_valid && prev_valid && !prev_hs && (pix_data != prev_data))
            stall_err <= stall_err + 1;
        prev_valid <= pix_valid;
        prev_hs    <= pix_valid && pix_ready;
        prev_data  <= pix_data;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int i = 0; i < 2000 && done_cnt < target; i++) step(1);
        check(tag, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 200 && !pix_valid; i++) step(1);
        check(tag, 32'(pix_valid), 32'd1);
    endtask

    int h0, r0, s;

    initial begin
        step(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fc", 32'(frame_count), 32'd0);
        check("rst_pix", 32'(pix_data), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        ARESETN = 1'b1;
        step(2);

        // Single frame, full throughput
        h0 = hs_cnt; r0 = rd_cnt;
        base_addr = 8'h10; num_pixels = 9'd3;
        pulse_start();
        check("t1_busy_t0", 32'(busy), 32'd1);
        check("t1_rd_t0", 32'(mem_rd_en), 32'd1);
        check("t1_addr_t0", 32'(mem_addr), 32'h10);
        step(1);
        check("t1_rd_t1", 32'(mem_rd_en), 32'd0);
        check("t1_valid_t1", 32'(pix_valid), 32'd0);
        step(1);
        check("t1_valid_t2", 32'(pix_valid), 32'd1);
        check("t1_data_t2", 32'(pix_data), 32'h101010);
        wait_done(1, "t1_done_to");
        check("t1_hs_cnt", 32'(hs_cnt - h0), 32'd3);
        check("t1_d0", 32'(hs_log[h0]), 32'h101010);
        check("t1_d1", 32'(hs_log[h0+1]), 32'h111111);
        check("t1_d2", 32'(hs_log[h0+2]), 32'h121212);
        check("t1_gap", 32'(done_cyc - last_hs_cyc), 32'(R + 1));
        check("t1_fc", 32'(frame_count), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_rd_cnt", 32'(rd_cnt - r0), 32'd3);

        // Back-pressure with address wrap
        h0 = hs_cnt; r0 = rd_cnt;
        pix_ready = 1'b0;
        base_addr = 8'hFE; num_pixels = 9'd4;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            wait_valid("t2_valid_to");
            step(5);
            pix_ready = 1'b1;
            step(1);
            pix_ready = 1'b0;
        end
        wait_done(2, "t2_done_to");
        pix_ready = 1'b1;
        check("t2_rd_cnt", 32'(rd_cnt - r0), 32'd4);
        check("t2_a0", 32'(rd_log[r0]), 32'hFE);
        check("t2_a1", 32'(rd_log[r0+1]), 32'hFF);
        check("t2_a2", 32'(rd_log[r0+2]), 32'h00);
        check("t2_a3", 32'(rd_log[r0+3]), 32'h01);
        check("t2_d0", 32'(hs_log[h0]), 32'hFEFEFE);
        check("t2_d2", 32'(hs_log[h0+2]), 32'h000000);
        check("t2_d3", 32'(hs_log[h0+3]), 32'h010101);
        check("t2_stable", 32'(stall_err), 32'd0);
        check("t2_fc", 32'(frame_count), 32'd2);

        // Latch gap restarts when the line goes busy
        h0 = hs_cnt;
        base_addr = 8'h40; num_pixels = 9'd1;
        pulse_start();
        for (int i = 0; i < 50 && hs_cnt == h0; i++) step(1);
        check("t3_hs", 32'(hs_cnt - h0), 32'd1);
        step(5);
        ser_idle = 1'b0;
        step(10);
        ser_idle = 1'b1;
        s = cyc;
        wait_done(3, "t3_done_to");
        check("t3_gap", 32'(done_cyc - s), 32'(R));
        check("t3_fc", 32'(frame_count), 32'd3);

        // Continuous frames, then abort during SEND
        h0 = hs_cnt; r0 = rd_cnt;
        base_addr = 8'h20; num_pixels = 9'd2; continuous = 1'b1;
        pulse_start();
        continuous = 1'b0;
        wait_done(6, "t4_done3_to");
        check("t4_fc3", 32'(frame_count), 32'd6);
        check("t4_busy_cont", 32'(busy), 32'd1);
        pix_ready = 1'b0;
        wait_valid("t4_valid_to");
        abort = 1'b1;
        step(2);
        check("t4_hold_valid", 32'(pix_valid), 32'd1);
        pix_ready = 1'b1;
        step(1);
        check("t4_after_hs", 32'(pix_valid), 32'd0);
        wait_done(7, "t4_done4_to");
        abort = 1'b0;
        check("t4_busy_end", 32'(busy), 32'd0);
        check("t4_fc4", 32'(frame_count), 32'd7);
        check("t4_hs_cnt", 32'(hs_cnt - h0), 32'd7);
        check("t4_rd_cnt", 32'(rd_cnt - r0), 32'd7);
        check("t4_d1", 32'(hs_log[h0+1]), 32'h212121);
        check("t4_d6", 32'(hs_log[h0+6]), 32'h202020);

        // Latch-only frame; a start while busy is ignored
        r0 = rd_cnt;
        base_addr = 8'h00; num_pixels = 9'd0;
        start = 1'b1;
        s = cyc;
        step(1);
        start = 1'b0;
        step(5);
        num_pixels = 9'd5;
        pulse_start();
        wait_done(8, "t5_done_to");
        check("t5_gap", 32'(done_cyc - s), 32'(R + 1));
        check("t5_no_rd", 32'(rd_cnt - r0), 32'd0);
        step(3);
        check("t5_busy_end", 32'(busy), 32'd0);
        check("t5_one_done", 32'(done_cnt), 32'd8);
        check("t5_fc", 32'(frame_count), 32'd8);

        // Asynchronous reset mid-SEND, then a normal frame
        pix_ready = 1'b0;
        base_addr = 8'h30; num_pixels = 9'd2;
        pulse_start();
        wait_valid("t6_valid_to");
        #2 ARESETN = 1'b0;
        #1;
        check("t6_rst_valid", 32'(pix_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_pix", 32'(pix_data), 32'd0);
        check("t6_rst_fc", 32'(frame_count), 32'd0);
        check("t6_rst_rd", 32'(mem_rd_en), 32'd0);
        step(1);
        ARESETN = 1'b1;
        pix_ready = 1'b1;
        h0 = hs_cnt;
        base_addr = 8'h33; num_pixels = 9'd1;
        pulse_start();
        wait_done(9, "t6_done_to");
        check("t6_d0", 32'(hs_log[h0]), 32'h333333);
        check("t6_fc", 32'(frame_count), 32'd1);
        check("t6_busy_end", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/neopixel_frame_sequencer.md
# neopixel_frame_sequencer

Frame-level controller for the NeoPixel output path. It sits between the AXI-lite control registers and the pixel RAM / bit serializer. It fetches a programmed number of 24-bit GRB words from pixel RAM and hands them one at a time to the serializer. After the last pixel it enforces the strip latch (reset) gap, then signals frame completion, either once or continuously.

## Interface
- ADDR_W, 8: pixel RAM address width; up to 2^ADDR_W pixels per frame.
- RESET_CYCLES, 2500: latch-gap length in ACLK cycles (50 us at 50 MHz); must be ≥ 2.
- ACLK  in  1  clock, all logic rising-edge.
- ARESETN  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- abort  in  1  level; stops the sequence at the next safe point.
- continuous  in  1  sampled at start; 1 = repeat frames until abort.
- base_addr  in  ADDR_W  first pixel RAM address, sampled at start.
- num_pixels  in  ADDR_W+1  pixels per frame, sampled at start; 0 = latch-only frame.
- mem_rd_en  out  1  RAM read strobe.
- mem_addr  out  ADDR_W  RAM read address.
- mem_rd_data  in  24  RAM data, valid the cycle after mem_rd_en (registered read).
- pix_valid  out  1  pixel word available to serializer.
- pix_data  out  24  GRB pixel word.
- pix_ready  in  1  serializer accepts word when pix_valid & pix_ready.
- ser_idle  in  1  serializer line idle (last bit fully shifted out).
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse per completed frame.
- frame_count  out  16  completed frames since reset, wraps 0xFFFF→0.

## Operation
- States: IDLE, FETCH, LOAD, SEND, LATCH, DONE.
- IDLE: on start, latch base_addr, num_pixels, continuous; idx←0. Go to LATCH if num_pixels==0, else go to FETCH. A start pulse seen outside IDLE is ignored.
- FETCH: mem_rd_en=1, mem_addr=(base_q+idx) mod 2^ADDR_W, so the address wraps around the RAM. Next state LOAD.
- LOAD: capture mem_rd_data into pix_data. Next state SEND.
- SEND: pix_valid=1 and pix_data held stable until the handshake. On handshake: if idx==num_q-1, go to LATCH; else idx++ and go to FETCH.
- LATCH: gap counter increments only while ser_idle=1 and clears to 0 whenever ser_idle=0. When the counter reaches RESET_CYCLES-1 with ser_idle=1, go to DONE.
- DONE: done=1 and frame_count++. Then go to IDLE if continuous_q=0 or abort=1; else idx←0 and go to FETCH (or to LATCH if num_q==0).
- abort in FETCH or LOAD: go to LATCH immediately, discarding any fetched word.
- abort in SEND: deferred until the handshake completes, then go to LATCH. pix_valid is never withdrawn without a handshake.
- abort in LATCH: no effect; the gap completes so the strip latches cleanly.
- abort in DONE: go to IDLE. An aborted frame still pulses done and counts.
- abort in IDLE: no effect. start and abort in the same IDLE cycle: start wins, and abort is evaluated from FETCH onward.

## Timing
- Reset values: state IDLE; mem_rd_en, pix_valid, busy, done = 0; mem_addr, pix_data, frame_count, idx, gap counter = 0.
- Edge at which start is sampled = t0. From t0: busy=1, mem_rd_en=1 (FETCH). From t1: LOAD. From t2: pix_valid=1.
- With pix_ready held high, the first handshake occurs at edge t3. Steady state is 3 cycles per pixel.
- mem_rd_en is a single-cycle pulse per pixel. Exactly one read is issued per pixel.
- Latch gap: exactly RESET_CYCLES consecutive ser_idle=1 cycles in LATCH before DONE.
- done is high for exactly one cycle. busy stays high during DONE in continuous mode.
- frame_count updates on the same edge that leaves DONE.

## Test plan
- Single frame: base=0x10, num=3, pix_ready=1, ser_idle=1, RAM[i]=i*0x010101. Required:
  - exactly 3 handshakes with data 0x101010, 0x111111, 0x121212;
  - first pix_valid at t0+2 cycles;
  - done exactly RESET_CYCLES cycles after LATCH entry;
  - frame_count=1, busy=0 afterwards.
- Back-pressure and wrap: base=0xFE, num=4, pix_ready low for 5 cycles per word. Required: addresses 0xFE, 0xFF, 0x00, 0x01; pix_data stable while stalled; no extra mem_rd_en.
- Latch gating: ser_idle drops for 10 cycles midway through LATCH. Required: gap counter restarts; done occurs RESET_CYCLES ser_idle-cycles after ser_idle returns high.
- Continuous and abort: continuous=1, num=2. Required:
  - three done pulses, frame_count=3;
  - abort asserted during the SEND of frame 4 completes that handshake, enters LATCH, pulses done, then IDLE with frame_count=4.
- Edge cases:
  - num=0 start yields a latch-only frame (no mem_rd_en, done after RESET_CYCLES);
  - start asserted while busy is ignored;
  - ARESETN low mid-SEND forces all outputs to reset values asynchronously, and a subsequent start runs normally.
